// File: rtl/pkt_hdr_capture.sv
// ---------------------------------------------------------------------------
// pkt_hdr_capture
//
// Snoops an already-qualified AXI Stream and builds one header record per
// packet. The first HDR_BEATS beats are collected into a zero-padded,
// byte-masked vector, and the valid header bytes are counted. The record is
// presented for one cycle on hdr_valid. It feeds the header-vector FIFO that
// the reassembly stage drains one record per packet.
//
// Ports:
//   axis_clk      - single clock, rising edge
//   aresetn       - asynchronous active-low reset
//   s_axis_tdata  - stream data
//   s_axis_tkeep  - byte enables, bit i covers tdata[8i+:8]
//   s_axis_tvalid - beat accepted this cycle (already ANDed with tready)
//   s_axis_tlast  - last beat of the packet
//   hdr_valid     - one-cycle pulse, a record is on the outputs
//   hdr_vec       - captured header, beat k at [k*W +: W]
//   hdr_len       - number of valid header bytes (tkeep popcount)
//   hdr_beats     - number of beats captured (1..HDR_BEATS)
//   hdr_trunc     - packet continues past the captured window
//   rec_cnt       - records emitted since reset, wraps
// ---------------------------------------------------------------------------
module pkt_hdr_capture #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int HDR_BEATS           = 4,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                                   axis_clk,
  input  logic                                   aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   hdr_valid,
  output logic [HDR_BEATS*C_S_AXIS_DATA_WIDTH-1:0] hdr_vec,
  output logic [7:0]                             hdr_len,
  output logic [2:0]                             hdr_beats,
  output logic                                   hdr_trunc,
  output logic [CNT_WIDTH-1:0]                   rec_cnt
);

  localparam int W      = C_S_AXIS_DATA_WIDTH;
  localparam int KEEP_W = W / 8;
  localparam int VEC_W  = HDR_BEATS * W;
  localparam int IDX_W  = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int PC_W   = $clog2(KEEP_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BEATS - 1);

  // hdr_len is 8 bits and hdr_beats is 3 bits, so the window must fit both.
  if ((W % 8 != 0) || (HDR_BEATS < 1) || (HDR_BEATS > 7) ||
      (HDR_BEATS * KEEP_W > 255)) begin : g_param_check
    $error("pkt_hdr_capture: unsupported parameter combination");
  end

  typedef enum logic [0:0] {
    CAPTURE = 1'b0,
    SKIP    = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  beat_idx, beat_idx_next;
  logic [VEC_W-1:0]  acc_vec, acc_vec_next;
  logic [7:0]        acc_len, acc_len_next;

  logic [W-1:0]      masked_beat;
  logic [PC_W-1:0]   keep_pop;
  logic [VEC_W-1:0]  cap_vec;
  logic [7:0]        cap_len;
  logic              emit;

  // Per-byte masking of the incoming beat and popcount of its tkeep.
  always_comb begin
    masked_beat = '0;
    keep_pop    = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      masked_beat[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
      keep_pop              = keep_pop + PC_W'(s_axis_tkeep[i]);
    end
  end

  // Accumulator view that already includes the current beat; it is both the
  // next accumulator value and the record contents on a terminating beat.
  always_comb begin
    cap_vec = acc_vec;
    cap_vec[int'(beat_idx)*W +: W] = masked_beat;
    cap_len = acc_len + 8'(keep_pop);
  end

  // FSM state and accumulator registers.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= CAPTURE;
      beat_idx <= '0;
      acc_vec  <= '0;
      acc_len  <= '0;
    end else begin
      state    <= state_next;
      beat_idx <= beat_idx_next;
      acc_vec  <= acc_vec_next;
      acc_len  <= acc_len_next;
    end
  end

  // Next-state logic. A terminating beat clears the accumulator in the same
  // edge that loads the outputs, so the next packet may start immediately.
  always_comb begin
    state_next    = state;
    beat_idx_next = beat_idx;
    acc_vec_next  = acc_vec;
    acc_len_next  = acc_len;
    emit          = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        CAPTURE: begin
          if (s_axis_tlast || (beat_idx == LAST_IDX)) begin
            emit          = 1'b1;
            acc_vec_next  = '0;
            acc_len_next  = '0;
            beat_idx_next = '0;
            state_next    = s_axis_tlast ? CAPTURE : SKIP;
          end else begin
            acc_vec_next  = cap_vec;
            acc_len_next  = cap_len;
            beat_idx_next = beat_idx + IDX_W'(1);
          end
        end
        SKIP: begin
          if (s_axis_tlast) begin
            state_next = CAPTURE;
          end
        end
        default: begin
          state_next = CAPTURE;
        end
      endcase
    end
  end

  // Output record registers; they hold until the next emission.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      hdr_valid <= 1'b0;
      hdr_vec   <= '0;
      hdr_len   <= '0;
      hdr_beats <= '0;
      hdr_trunc <= 1'b0;
      rec_cnt   <= '0;
    end else begin
      hdr_valid <= emit;
      if (emit) begin
        hdr_vec   <= cap_vec;
        hdr_len   <= cap_len;
        hdr_beats <= 3'(int'(beat_idx) + 1);
        hdr_trunc <= ~s_axis_tlast;
        rec_cnt   <= rec_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pkt_hdr_capture.sv
// ---------------------------------------------------------------------------
// tb_pkt_hdr_capture
//
// Directed self-checking bench for pkt_hdr_capture with default parameters.
// A negedge monitor collects every hdr_valid record into a queue; each test
// drives a packet, then pops and compares the records it expects.
// ---------------------------------------------------------------------------
module tb_pkt_hdr_capture;

  localparam int W  = 256;
  localparam int HB = 4;
  localparam int CW = 32;

  logic              axis_clk = 1'b0;
  logic              aresetn;
  logic [W-1:0]      s_axis_tdata;
  logic [W/8-1:0]    s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              hdr_valid;
  logic [HB*W-1:0]   hdr_vec;
  logic [7:0]        hdr_len;
  logic [2:0]        hdr_beats;
  logic              hdr_trunc;
  logic [CW-1:0]     rec_cnt;

  typedef struct {
    logic [HB*W-1:0] vec;
    logic [7:0]      len;
    logic [2:0]      beats;
    logic            trunc;
    logic [CW-1:0]   cnt;
    int              cyc;
  } rec_t;

  rec_t rec_q[$];
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pkt_hdr_capture #(
    .C_S_AXIS_DATA_WIDTH(W),
    .HDR_BEATS(HB),
    .CNT_WIDTH(CW)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .hdr_valid(hdr_valid),
    .hdr_vec(hdr_vec),
    .hdr_len(hdr_len),
    .hdr_beats(hdr_beats),
    .hdr_trunc(hdr_trunc),
    .rec_cnt(rec_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Record collector, sampling half a cycle away from the active edge.
  always @(negedge axis_clk) begin
    if (hdr_valid === 1'b1) begin
      rec_t r;
      r.vec   = hdr_vec;
      r.len   = hdr_len;
      r.beats = hdr_beats;
      r.trunc = hdr_trunc;
      r.cnt   = rec_cnt;
      r.cyc   = cyc;
      rec_q.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] ramp(input logic [7:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < W/8; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] v, input logic [W/8-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W/8; i++) r[8*i +: 8] = k[i] ? v[8*i +: 8] : 8'h00;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [HB*W-1:0] v,
                          input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input logic [W-1:0] e3);
    checkOutput($sformatf("%s_slot0", tag), v[0*W +: W], e0);
    checkOutput($sformatf("%s_slot1", tag), v[1*W +: W], e1);
    checkOutput($sformatf("%s_slot2", tag), v[2*W +: W], e2);
    checkOutput($sformatf("%s_slot3", tag), v[3*W +: W], e3);
  endtask

  // One accepted beat; consecutive calls give back-to-back beats.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [W/8-1:0] k, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(posedge axis_clk);
    #1;
    last_acc_cyc  = cyc;
    s_axis_tvalid = 1'b0;
  endtask

  // Idle cycles with junk on the bus that must be ignored.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = {8{$urandom()}};
      s_axis_tkeep  = $urandom();
      s_axis_tlast  = 1'b1;
      @(posedge axis_clk);
      #1;
    end
  endtask

  task automatic popRecord(input string tag, output rec_t r);
    checkOutput($sformatf("%s_present", tag), W'(rec_q.size() > 0), W'(1));
    if (rec_q.size() > 0) r = rec_q.pop_front();
    else r = '{default: '0};
  endtask

  initial begin
    rec_t r, r2, ref_rec;
    int   beat3_cyc;
    logic [W-1:0] full_k;
    full_k = '1;

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    checkOutput("rst_valid", W'(hdr_valid), '0);
    checkVec("rst_vec", hdr_vec, '0, '0, '0, '0);
    checkOutput("rst_len", W'(hdr_len), '0);
    checkOutput("rst_beats", W'(hdr_beats), '0);
    checkOutput("rst_cnt", W'(rec_cnt), '0);
    @(negedge axis_clk);
    aresetn = 1'b1;

    // Single beat, lower 16 bytes valid.
    $display("[TB] test 1: single beat");
    applyStimulus(ramp(8'h00), 32'h0000FFFF, 1'b1);
    waitCycles(2);
    checkOutput("t1_count", W'(rec_q.size()), W'(1));
    popRecord("t1", r);
    checkOutput("t1_latency", W'(r.cyc), W'(last_acc_cyc));
    checkOutput("t1_len", W'(r.len), W'(16));
    checkOutput("t1_beats", W'(r.beats), W'(1));
    checkOutput("t1_trunc", W'(r.trunc), '0);
    checkOutput("t1_cnt", W'(r.cnt), W'(1));
    checkVec("t1_vec", r.vec, 256'h0f0e0d0c0b0a09080706050403020100, '0, '0, '0);

    // Three beats, last one with 8 bytes.
    $display("[TB] test 2: three beats");
    applyStimulus(ramp(8'h20), full_k[31:0], 1'b0);
    applyStimulus(ramp(8'h40), full_k[31:0], 1'b0);
    applyStimulus(ramp(8'h60), 32'h000000FF, 1'b1);
    waitCycles(2);
    checkOutput("t2_count", W'(rec_q.size()), W'(1));
    popRecord("t2", r);
    checkOutput("t2_len", W'(r.len), W'(72));
    checkOutput("t2_beats", W'(r.beats), W'(3));
    checkOutput("t2_trunc", W'(r.trunc), '0);
    checkOutput("t2_cnt", W'(r.cnt), W'(2));
    checkVec("t2_vec", r.vec, ramp(8'h20), ramp(8'h40), 256'h6766656463626160, '0);

    // Ten-beat packet, truncated after four.
    $display("[TB] test 3: ten beats");
    beat3_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(ramp(8'(k * 16)), full_k[31:0], k == 9);
      if (k == 3) beat3_cyc = last_acc_cyc;
    end
    waitCycles(2);
    checkOutput("t3_count", W'(rec_q.size()), W'(1));
    popRecord("t3", r);
    checkOutput("t3_latency", W'(r.cyc), W'(beat3_cyc));
    checkOutput("t3_len", W'(r.len), W'(128));
    checkOutput("t3_beats", W'(r.beats), W'(4));
    checkOutput("t3_trunc", W'(r.trunc), W'(1));
    checkOutput("t3_cnt", W'(r.cnt), W'(3));
    checkVec("t3_vec", r.vec, ramp(8'h00), ramp(8'h10), ramp(8'h20), ramp(8'h30));

    // Four beats ending exactly on the window, then a one-beat packet.
    $display("[TB] test 4: back-to-back");
    for (int k = 0; k < 4; k++) applyStimulus(ramp(8'(8'h40 + k * 32)), full_k[31:0], k == 3);
    applyStimulus(ramp(8'h80), 32'h0000000F, 1'b1);
    waitCycles(2);
    checkOutput("t4_count", W'(rec_q.size()), W'(2));
    popRecord("t4a", r);
    popRecord("t4b", r2);
    checkOutput("t4_consecutive", W'(r2.cyc), W'(r.cyc + 1));
    checkOutput("t4a_len", W'(r.len), W'(128));
    checkOutput("t4a_beats", W'(r.beats), W'(4));
    checkOutput("t4a_trunc", W'(r.trunc), '0);
    checkVec("t4a_vec", r.vec, ramp(8'h40), ramp(8'h60), ramp(8'h80), ramp(8'hA0));
    checkOutput("t4b_len", W'(r2.len), W'(4));
    checkOutput("t4b_beats", W'(r2.beats), W'(1));
    checkOutput("t4b_trunc", W'(r2.trunc), '0);
    checkOutput("t4b_cnt", W'(r2.cnt), W'(5));
    checkVec("t4b_vec", r2.vec, 256'h83828180, '0, '0, '0);

    // Two-beat packet, gap-free then with random tvalid gaps.
    $display("[TB] test 5: tvalid gaps");
    applyStimulus(ramp(8'h05), full_k[31:0], 1'b0);
    applyStimulus(ramp(8'hA0), 32'h00FF00FF, 1'b1);
    waitCycles(2);
    checkOutput("t5_count_a", W'(rec_q.size()), W'(1));
    popRecord("t5a", ref_rec);
    checkOutput("t5a_len", W'(ref_rec.len), W'(48));
    checkOutput("t5a_cnt", W'(ref_rec.cnt), W'(6));
    checkVec("t5a_vec", ref_rec.vec, ramp(8'h05), mask_bytes(ramp(8'hA0), 32'h00FF00FF), '0, '0);
    waitCycles($urandom_range(1, 3));
    applyStimulus(ramp(8'h05), full_k[31:0], 1'b0);
    waitCycles($urandom_range(1, 4));
    applyStimulus(ramp(8'hA0), 32'h00FF00FF, 1'b1);
    waitCycles(2);
    checkOutput("t5_count_b", W'(rec_q.size()), W'(1));
    popRecord("t5b", r);
    checkVec("t5b_vec", r.vec, ref_rec.vec[0 +: W], ref_rec.vec[W +: W],
             ref_rec.vec[2*W +: W], ref_rec.vec[3*W +: W]);
    checkOutput("t5b_len", W'(r.len), W'(ref_rec.len));
    checkOutput("t5b_beats", W'(r.beats), W'(2));
    checkOutput("t5b_trunc", W'(r.trunc), '0);
    checkOutput("t5b_cnt", W'(r.cnt), W'(7));

    // Reset in the middle of a six-beat packet.
    $display("[TB] test 6: reset mid-packet");
    applyStimulus(ramp(8'hC0), full_k[31:0], 1'b0);
    applyStimulus(ramp(8'hE0), full_k[31:0], 1'b0);
    aresetn = 1'b0;
    #2;
    checkOutput("t6_rst_valid", W'(hdr_valid), '0);
    checkVec("t6_rst_vec", hdr_vec, '0, '0, '0, '0);
    checkOutput("t6_rst_len", W'(hdr_len), '0);
    checkOutput("t6_rst_beats", W'(hdr_beats), '0);
    checkOutput("t6_rst_trunc", W'(hdr_trunc), '0);
    checkOutput("t6_rst_cnt", W'(rec_cnt), '0);
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    aresetn = 1'b1;
    applyStimulus(ramp(8'h33), full_k[31:0], 1'b0);
    applyStimulus(ramp(8'h55), 32'h00000001, 1'b1);
    waitCycles(3);
    checkOutput("t6_count", W'(rec_q.size()), W'(1));
    popRecord("t6", r);
    checkOutput("t6_len", W'(r.len), W'(33));
    checkOutput("t6_beats", W'(r.beats), W'(2));
    checkOutput("t6_trunc", W'(r.trunc), '0);
    checkOutput("t6_cnt", W'(r.cnt), W'(1));
    checkVec("t6_vec", r.vec, ramp(8'h33), 256'h55, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
